// File: rtl/tile_render_pkg.sv
// Shared constants and FSM encoding for the tile-grid sprite renderer.
package tile_render_pkg;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] LEFT  = 2'd3;

  localparam int         TILE_PX      = 8;
  localparam logic [3:0] BLANK_SPRITE = 4'hF;

  typedef enum logic [1:0] {BLANK, PREFETCH, READY, DRAW} stream_state_t;

endpackage

// File: rtl/tile_pixel_streamer_scale_counter.sv
// Sub-step / bit / tile-index counter. Outputs reflect the current position
// (a clear forces zero in the same cycle) plus the tile index after this cycle.
module scale_counter
  import tile_render_pkg::*;
#(
  parameter int SCALE = 5,
  parameter int IDX_W = 4,
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [SUB_W-1:0] sub,
  output logic [2:0]       bit_idx,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next
);

  logic [SUB_W-1:0] sub_q, sub_n;
  logic [2:0]       bit_q, bit_n;
  logic [IDX_W-1:0] idx_q;

  always_comb begin
    sub      = clear ? '0 : sub_q;
    bit_idx  = clear ? '0 : bit_q;
    idx      = clear ? '0 : idx_q;
    sub_n    = sub;
    bit_n    = bit_idx;
    idx_next = idx;
    if (advance) begin
      if (sub == SUB_W'(SCALE - 1)) begin
        sub_n = '0;
        if (bit_idx == 3'(TILE_PX - 1)) begin
          bit_n    = '0;
          idx_next = idx + IDX_W'(1);
        end else begin
          bit_n = bit_idx + 3'd1;
        end
      end else begin
        sub_n = sub + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_n;
      bit_q <= bit_n;
      idx_q <= idx_next;
    end
  end

endmodule

// File: rtl/tile_pixel_streamer.sv
// Walks the tile grid under the beam, fetches sprite slices from SpriteROM a
// tile ahead, and streams the double-buffered slice out as a scaled 1-bit pixel.
module tile_pixel_streamer
  import tile_render_pkg::*;
#(
  parameter int PIX_SCALE = 5,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  output logic [3:0] tile_col,
  output logic [3:0] tile_row,
  input  logic [3:0] map_sprite_id,
  input  logic [1:0] map_orientation,
  output logic [3:0] rom_sprite_id,
  output logic [1:0] rom_orientation,
  output logic [2:0] rom_line_index,
  input  logic [7:0] rom_data,
  output logic       pixel_on
);

  localparam int SUB_W = (PIX_SCALE > 1) ? $clog2(PIX_SCALE) : 1;

  logic             hblank_entry, tile_start, fetch_issue;
  logic             fetch_p1, fetch_p2;
  logic [SUB_W-1:0] h_sub, v_sub_unused;
  logic [2:0]       h_bit, v_bit;
  logic [3:0]       h_tile, h_tile_next_unused, v_row, v_row_next;
  logic [7:0]       cur_slice, next_slice, shown_slice;
  stream_state_t    state_q, state_n;
  logic             load_cur, drawing;

  assign hblank_entry = (pix_x == 10'(H_ACTIVE));
  assign tile_start   = video_active && (h_sub == '0) && (h_bit == 3'd0);
  assign fetch_issue  = hblank_entry || tile_start;

  scale_counter #(.SCALE(PIX_SCALE), .IDX_W(4)) h_count (
    .clk      (clk),
    .reset    (reset),
    .clear    (pix_x == 10'd0),
    .advance  (video_active),
    .sub      (h_sub),
    .bit_idx  (h_bit),
    .idx      (h_tile),
    .idx_next (h_tile_next_unused)
  );

  // Vertical position is stepped on hblank entry so it already names the next line.
  scale_counter #(.SCALE(PIX_SCALE), .IDX_W(4)) v_count (
    .clk      (clk),
    .reset    (reset),
    .clear    (hblank_entry && (pix_y == 10'(V_TOTAL - 1))),
    .advance  (hblank_entry && (pix_y < 10'(V_ACTIVE - 1))),
    .sub      (v_sub_unused),
    .bit_idx  (v_bit),
    .idx      (v_row),
    .idx_next (v_row_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_col        <= '0;
      tile_row        <= '0;
      fetch_p1        <= 1'b0;
      fetch_p2        <= 1'b0;
      rom_sprite_id   <= BLANK_SPRITE;
      rom_orientation <= UP;
      rom_line_index  <= '0;
      next_slice      <= 8'hFF;
    end else begin
      fetch_p1 <= fetch_issue;
      fetch_p2 <= fetch_p1;
      if (fetch_issue) begin
        tile_col <= hblank_entry ? 4'd0 : h_tile + 4'd1;
        tile_row <= v_row_next;
      end
      if (fetch_p1) begin
        rom_sprite_id   <= map_sprite_id;
        rom_orientation <= map_orientation;
        rom_line_index  <= v_bit;
      end
      if (fetch_p2) begin
        next_slice <= rom_data;
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    load_cur = 1'b0;
    drawing  = 1'b0;
    case (state_q)
      BLANK: begin
        if (hblank_entry) state_n = PREFETCH;
      end
      PREFETCH: begin
        if (fetch_p2) state_n = READY;
      end
      READY: begin
        if (hblank_entry) begin
          state_n = PREFETCH;
        end else if ((pix_x == 10'd0) && video_active) begin
          load_cur = 1'b1;
          drawing  = 1'b1;
          state_n  = DRAW;
        end
      end
      DRAW: begin
        if (video_active) begin
          drawing  = 1'b1;
          load_cur = tile_start;
        end else begin
          state_n = hblank_entry ? PREFETCH : BLANK;
        end
      end
      default: state_n = BLANK;
    endcase
  end

  // The slice being loaded this cycle already drives the first pixel of its tile.
  assign shown_slice = load_cur ? next_slice : cur_slice;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BLANK;
      cur_slice <= 8'hFF;
      pixel_on  <= 1'b0;
    end else begin
      state_q  <= state_n;
      pixel_on <= drawing & ~shown_slice[h_bit];
      if (load_cur) cur_slice <= next_slice;
    end
  end

endmodule

// File: tb/tb_tile_pixel_streamer.sv
// Randomized scoreboard bench for tile_pixel_streamer with a behavioural
// tile-map / SpriteROM model on a shortened raster.
module tb_tile_pixel_streamer;

  localparam int S    = 5;
  localparam int HA   = 120;
  localparam int VA   = 48;
  localparam int VT   = 52;
  localparam int HT   = 126;
  localparam int TILE = 8 * S;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic       video_active;
  logic [3:0] tile_col, tile_row, map_sprite_id, rom_sprite_id;
  logic [1:0] map_orientation, rom_orientation;
  logic [2:0] rom_line_index;
  logic [7:0] rom_data;
  logic       pixel_on;

  logic [3:0] map_id  [16][16];
  logic [1:0] map_or  [16][16];
  logic [7:0] rom_tbl [16][4][8];

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  exp_q[$];
  bit  mon_exp;
  int  vline = 0;
  bit  ready = 1'b0;
  bit  clean = 1'b1;
  int  last_x = -1;
  int  last_y = -1;
  bit  last_rst = 1'b0;

  always #5 clk = ~clk;

  assign map_sprite_id   = map_id[tile_col][tile_row];
  assign map_orientation = map_or[tile_col][tile_row];
  assign rom_data        = rom_tbl[rom_sprite_id][rom_orientation][rom_line_index];

  tile_pixel_streamer #(
    .PIX_SCALE (S),
    .H_ACTIVE  (HA),
    .V_ACTIVE  (VA),
    .V_TOTAL   (VT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .video_active    (video_active),
    .tile_col        (tile_col),
    .tile_row        (tile_row),
    .map_sprite_id   (map_sprite_id),
    .map_orientation (map_orientation),
    .rom_sprite_id   (rom_sprite_id),
    .rom_orientation (rom_orientation),
    .rom_line_index  (rom_line_index),
    .rom_data        (rom_data),
    .pixel_on        (pixel_on)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: actual %0d required %0d", name, $time, actual, expected);
    end
  endtask

  task automatic randomize_world(input bit forced);
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 16; r++) begin
        map_id[c][r] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        map_or[c][r] = 2'($urandom_range(0, 3));
      end
    end
    for (int id = 0; id < 16; id++)
      for (int o = 0; o < 4; o++)
        for (int l = 0; l < 8; l++)
          rom_tbl[id][o][l] = (id == 15) ? 8'hFF : 8'($urandom);
    if (forced) begin
      map_id[0][0]     = 4'd1;
      map_or[0][0]     = 2'd0;
      map_id[1][0]     = 4'hF;
      rom_tbl[1][0][1] = 8'b10011001;
    end
  endtask

  // Screen pixel x on logical line vl: pick the tile, its sprite line, then the bit.
  function automatic bit model_pixel(input int x, input int vl);
    int         col, row, ln;
    logic [7:0] sl;
    col = x / TILE;
    row = vl / TILE;
    ln  = (vl / S) % 8;
    sl  = rom_tbl[map_id[col][row]][map_or[col][row]][ln];
    return ~sl[(x / S) % 8];
  endfunction

  task automatic directed_checks();
    int row, ln, col;
    row = vline / TILE;
    ln  = (vline / S) % 8;
    if (last_x == HA + 1 && ready) begin
      check_output("hblank_tile_col", tile_col, 0);
      check_output("hblank_tile_row", tile_row, row);
      check_output("hblank_line_index", rom_line_index, ln);
      check_output("hblank_rom_sprite", rom_sprite_id, map_id[0][row]);
      check_output("hblank_rom_orient", rom_orientation, map_or[0][row]);
      if (clean && last_y == 4) check_output("y4_line_index", rom_line_index, 1);
      if (clean && last_y == 39) begin
        check_output("y39_tile_row", tile_row, 1);
        check_output("y39_line_index", rom_line_index, 0);
      end
      if (last_y == VT - 1) begin
        check_output("wrap_tile_row", tile_row, 0);
        check_output("wrap_line_index", rom_line_index, 0);
      end
    end
    if (ready && last_y < VA && last_x < HA) begin
      col = last_x / TILE + 1;
      if (last_x % TILE == 0) check_output("inline_tile_col", tile_col, col);
      if (last_x % TILE == 1) begin
        check_output("inline_rom_sprite", rom_sprite_id, map_id[col][row]);
        check_output("inline_rom_orient", rom_orientation, map_or[col][row]);
        check_output("inline_line_index", rom_line_index, ln);
      end
    end
  endtask

  task automatic apply_stimulus(input int x, input int y, input bit va, input bit rst);
    @(negedge clk);
    if (!last_rst && last_x >= 0) directed_checks();
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    video_active = va;
    reset        = rst;
    if (rst) begin
      exp_q.push_back(1'b0);
      ready = 1'b0;
      vline = 0;
      clean = 1'b0;
      #1;
      check_output("midreset_pixel_on", pixel_on, 0);
      check_output("midreset_rom_sprite", rom_sprite_id, 15);
      check_output("midreset_tile_col", tile_col, 0);
      check_output("midreset_tile_row", tile_row, 0);
    end else begin
      exp_q.push_back((va && ready) ? model_pixel(x, vline) : 1'b0);
      if (x == HA) begin
        ready = 1'b1;
        if (y == VT - 1) vline = 0;
        else if (y < VA - 1) vline++;
      end
    end
    last_x   = x;
    last_y   = y;
    last_rst = rst;
  endtask

  // Monitor: every cycle's pixel_on is compared against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check_output("pixel_on", pixel_on, mon_exp);
      end
    end
  end

  initial begin
    reset        = 1'b1;
    pix_x        = '0;
    pix_y        = '0;
    video_active = 1'b0;
    randomize_world(1'b1);
    repeat (3) @(negedge clk);
    check_output("reset_pixel_on", pixel_on, 0);
    check_output("reset_tile_col", tile_col, 0);
    check_output("reset_tile_row", tile_row, 0);
    check_output("reset_rom_sprite", rom_sprite_id, 15);
    check_output("reset_rom_orient", rom_orientation, 0);
    check_output("reset_line_index", rom_line_index, 0);
    reset = 1'b0;

    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < VT; y++) begin
        if (y == 0) clean = 1'b1;
        if (f > 0 && y == VA) randomize_world(1'b0);
        for (int x = 0; x < HT; x++) begin
          apply_stimulus(x, y, (x < HA) && (y < VA), (f == 1) && (y == 10) && (x == 100));
        end
      end
    end

    repeat (2) @(posedge clk);
    #2;
    check_output("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
